wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
// Writeback stage of the rv64IM core, directly upstream of the register file's single write port.
// Merges two result sources onto that port:
//   - the in-order pipeline result (EX/MEM), which can never be stalled;
//   - results from the multi-cycle mul/div unit, via a valid/ready handshake.
// Mul/div results wait in a small FIFO until a pipeline-free writeback slot exists.
// pend_o tells ID which GPRs have a writeback still owed, so ID can stall on RAW/WAW hazards.
// PARAMETERS
// XLEN   64  data width of write data
// DEPTH  2   mul/div result FIFO entries (power of two, >=2)
// PORTS
// clock         in   1      core clock, all state on posedge
// reset         in   1      asynchronous, active-low reset
// pipe_wen_i    in   1      pipeline writeback request this cycle
// pipe_rd_i     in   5      pipeline destination register
// pipe_wdata_i  in   XLEN   pipeline write data
// md_valid_i    in   1      mul/div result valid
// md_ready_o    out  1      FIFO can accept a mul/div result
// md_rd_i       in   5      mul/div destination register
// md_wdata_i    in   XLEN   mul/div result
// wen_o         out  1      to regfile wen_i (registered)
// rd_o          out  5      to regfile rd_i (registered)
// wdata_o       out  XLEN   to regfile wdata_i (registered)
// pend_o        out  32     bit r set = mul/div write to xr queued or in wen_o stage
// count_o       out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - wen_o=0, rd_o=0, wdata_o=0;
//   - FIFO empty, count_o=0, pend_o=0, md_ready_o=1.
// - Handshake:
//   - A mul/div result is accepted on a posedge where md_valid_i && md_ready_o.
//   - md_ready_o = (count_o != DEPTH). It depends only on registered state and never on same-cycle dequeue.
//   - Rule: when full, no result is accepted even if an entry is draining that cycle.
// - Slot arbitration per cycle, in priority order:
//   1. pipe_wen_i && pipe_rd_i != 0: the output register loads the pipe write. A non-empty FIFO holds.
//   2. Else, FIFO non-empty: the head entry dequeues into the output register.
//   3. Else, an accepted md result with md_rd_i != 0 bypasses straight into the output register, not enqueued.
//   4. Else: wen_o <= 0, and rd_o/wdata_o hold their previous values.
// - In case 1 or 2, an accepted md result is enqueued at the tail.
//   - Enqueue and dequeue may occur in the same cycle; the count is then unchanged.
// - Writes to x0 from either source are dropped.
//   - An md result with rd=0 is still accepted (handshake completes) but is never enqueued.
//   - A pipe write to x0 frees the slot for the FIFO.
// - Latency:
//   - pipe request to wen_o: 1 cycle.
//   - md accept to wen_o: 1 cycle if bypassed, otherwise 1 + cycles queued.
// - FIFO ordering is strict FIFO. Read/write pointers wrap modulo DEPTH. count_o is the full count.
// - pend_o:
//   - OR of one-hot(rd) over valid FIFO entries;
//   - plus one-hot(rd_o) while wen_o is set from an md source;
//   - pipe-sourced writes never set pend_o.
//   - Updated registered, same edge as the FIFO.
// - Hazard contract: ID stalls any instruction whose rs1/rs2/rd bit is set in pend_o.
//   - This block therefore never reorders same-rd writes and performs no checks of its own.
// - Reset asserted mid-operation discards queued results. The mul/div unit is reset by the same signal.
// STRUCTURE
// - Shared package wb_pkg:
//   - XLEN;
//   - typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data;};
//   - localparam REG_X0 = 5'd0.
// - Sub-module wb_fifo (DEPTH x wb_entry_t, push/pop/full/empty/count, async active-low reset).
// - Arbitration and pend_o logic stay in wb_arbiter.
// TESTING
// - After reset: check wen_o=0, pend_o=0, md_ready_o=1, count_o=0.
// - Pipe x5=0xAA while idle -> next cycle wen_o=1, rd_o=5, wdata_o=0xAA. Then wen_o=0.
// - md x7=0x1234 with no pipe write -> bypass; next cycle wen_o=1, rd_o=7, pend_o[7]=1. Then pend_o=0.
// - Fill and drain:
//   - Stimulus: pipe writes x1..x4 every cycle; md pushes x8=1, x9=2 in consecutive cycles.
//   - Required: count_o reaches 2 and md_ready_o=0.
//   - A third md_valid_i stays unaccepted until pipe stops.
//   - Then the outputs write x8=1, then x9=2, in order.
// - md x0 accepted while idle -> handshake completes, wen_o stays 0, pend_o=0.
// - Reset low with 2 queued entries -> wen_o=0, count_o=0, pend_o=0 immediately (async).
//   After release, no stale write appears.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  localparam int XLEN = 64;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // One-hot GPR mask used to build the pending-write vector.
  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    rd_onehot = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding mul/div results until a writeback slot is free.
// Per-slot valid bits are exported so the parent can build its pending mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  wb_entry_t     mem [DEPTH];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Export storage so pending-register tracking can see every queued rd.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[i];
    end
  end

  // Pointer, occupancy and slot-valid bookkeeping; pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PW'(i))) begin
          valid[i] <= 1'b1;
        end else if (pop && (rd_ptr == PW'(i))) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  // Entry storage; data is only meaningful where the valid bit is set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the unstallable pipeline result with queued
// mul/div results onto the single register-file write port.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pipe_wen_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_wdata_i,
  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [4:0]      md_rd_i,
  input  logic [XLEN-1:0] md_wdata_i,
  output logic            wen_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [31:0]     pend_o,
  output logic [CW-1:0]   count_o
);

  logic             pipe_go;
  logic             md_accept;
  logic             md_live;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             out_from_md;
  wb_entry_t        md_entry;
  wb_entry_t        fifo_head;
  wb_entry_t        fifo_entries [DEPTH];
  logic [DEPTH-1:0] fifo_valid;

  // Ready comes from registered occupancy only, so a full FIFO refuses even while draining.
  assign md_ready_o = !fifo_full;
  assign md_accept  = md_valid_i && md_ready_o;
  assign md_live    = md_accept && (md_rd_i != REG_X0);
  assign pipe_go    = pipe_wen_i && (pipe_rd_i != REG_X0);
  assign md_entry   = '{rd: md_rd_i, data: md_wdata_i};

  // Queue an md result only when the slot is taken by the pipe or by an older entry.
  always_comb begin
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    if (pipe_go) begin
      fifo_push = md_live;
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      fifo_push = md_live;
    end
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (md_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count_o),
    .entries    (fifo_entries),
    .valid      (fifo_valid)
  );

  // Output register: pipe first, then FIFO head, then md bypass, else idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wen_o       <= 1'b0;
      rd_o        <= '0;
      wdata_o     <= '0;
      out_from_md <= 1'b0;
    end else if (pipe_go) begin
      wen_o       <= 1'b1;
      rd_o        <= pipe_rd_i;
      wdata_o     <= pipe_wdata_i;
      out_from_md <= 1'b0;
    end else if (!fifo_empty) begin
      wen_o       <= 1'b1;
      rd_o        <= fifo_head.rd;
      wdata_o     <= fifo_head.data;
      out_from_md <= 1'b1;
    end else if (md_live) begin
      wen_o       <= 1'b1;
      rd_o        <= md_rd_i;
      wdata_o     <= md_wdata_i;
      out_from_md <= 1'b1;
    end else begin
      wen_o       <= 1'b0;
      out_from_md <= 1'b0;
    end
  end

  // Pending mask built from registered state: queued rds plus an md write in the output stage.
  always_comb begin
    pend_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) begin
        pend_o = pend_o | rd_onehot(fifo_entries[i].rd);
      end
    end
    if (wen_o && out_from_md) begin
      pend_o = pend_o | rd_onehot(rd_o);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for the writeback arbiter.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic            clock;
  logic            reset;
  logic            pipe_wen_i;
  logic [4:0]      pipe_rd_i;
  logic [XLEN-1:0] pipe_wdata_i;
  logic            md_valid_i;
  logic            md_ready_o;
  logic [4:0]      md_rd_i;
  logic [XLEN-1:0] md_wdata_i;
  logic            wen_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] wdata_o;
  logic [31:0]     pend_o;
  logic [1:0]      count_o;

  int total_checks;
  int passed_checks;

  wb_arbiter #(.DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .pipe_wen_i   (pipe_wen_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_wdata_i (pipe_wdata_i),
    .md_valid_i   (md_valid_i),
    .md_ready_o   (md_ready_o),
    .md_rd_i      (md_rd_i),
    .md_wdata_i   (md_wdata_i),
    .wen_o        (wen_o),
    .rd_o         (rd_o),
    .wdata_o      (wdata_o),
    .pend_o       (pend_o),
    .count_o      (count_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic applyStimulus(input logic pw, input logic [4:0] prd, input logic [63:0] pdata,
                               input logic mv, input logic [4:0] mrd, input logic [63:0] mdata);
    pipe_wen_i   = pw;
    pipe_rd_i    = prd;
    pipe_wdata_i = pdata;
    md_valid_i   = mv;
    md_rd_i      = mrd;
    md_wdata_i   = mdata;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_wen", 64'(wen_o), 64'd0);
    checkOutput("rst_rd", 64'(rd_o), 64'd0);
    checkOutput("rst_wdata", wdata_o, 64'd0);
    checkOutput("rst_pend", 64'(pend_o), 64'd0);
    checkOutput("rst_ready", 64'(md_ready_o), 64'd1);
    checkOutput("rst_count", 64'(count_o), 64'd0);
    reset = 1'b1;
    tick();

    // Pipe write to x5 while idle.
    applyStimulus(1, 5, 64'hAA, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pipe_wen", 64'(wen_o), 64'd1);
    checkOutput("pipe_rd", 64'(rd_o), 64'd5);
    checkOutput("pipe_wdata", wdata_o, 64'hAA);
    checkOutput("pipe_pend", 64'(pend_o), 64'd0);
    tick();
    checkOutput("pipe_idle_wen", 64'(wen_o), 64'd0);
    checkOutput("pipe_hold_rd", 64'(rd_o), 64'd5);
    checkOutput("pipe_hold_wdata", wdata_o, 64'hAA);

    // md bypass to x7.
    applyStimulus(0, 0, 0, 1, 7, 64'h1234);
    #1;
    checkOutput("byp_ready", 64'(md_ready_o), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("byp_wen", 64'(wen_o), 64'd1);
    checkOutput("byp_rd", 64'(rd_o), 64'd7);
    checkOutput("byp_wdata", wdata_o, 64'h1234);
    checkOutput("byp_pend", 64'(pend_o), 64'h80);
    checkOutput("byp_count", 64'(count_o), 64'd0);
    tick();
    checkOutput("byp_idle_wen", 64'(wen_o), 64'd0);
    checkOutput("byp_idle_pend", 64'(pend_o), 64'd0);

    // Fill: pipe owns the slot, md results queue.
    applyStimulus(1, 1, 64'h11, 1, 8, 64'd1);
    tick();
    checkOutput("fill1_rd", 64'(rd_o), 64'd1);
    checkOutput("fill1_count", 64'(count_o), 64'd1);
    checkOutput("fill1_pend", 64'(pend_o), 64'h100);
    applyStimulus(1, 2, 64'h22, 1, 9, 64'd2);
    tick();
    checkOutput("fill2_rd", 64'(rd_o), 64'd2);
    checkOutput("fill2_count", 64'(count_o), 64'd2);
    checkOutput("fill2_ready", 64'(md_ready_o), 64'd0);
    checkOutput("fill2_pend", 64'(pend_o), 64'h300);
    applyStimulus(1, 3, 64'h33, 1, 10, 64'd3);
    tick();
    checkOutput("fill3_rd", 64'(rd_o), 64'd3);
    checkOutput("fill3_count", 64'(count_o), 64'd2);
    checkOutput("fill3_pend", 64'(pend_o), 64'h300);
    applyStimulus(1, 4, 64'h44, 1, 10, 64'd3);
    tick();
    checkOutput("fill4_rd", 64'(rd_o), 64'd4);
    checkOutput("fill4_count", 64'(count_o), 64'd2);

    // Drain: pipe stops, full FIFO still refuses x10 on this edge.
    applyStimulus(0, 0, 0, 1, 10, 64'd3);
    tick();
    checkOutput("drain1_wen", 64'(wen_o), 64'd1);
    checkOutput("drain1_rd", 64'(rd_o), 64'd8);
    checkOutput("drain1_wdata", wdata_o, 64'd1);
    checkOutput("drain1_count", 64'(count_o), 64'd1);
    checkOutput("drain1_pend", 64'(pend_o), 64'h300);
    checkOutput("drain1_ready", 64'(md_ready_o), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drain2_rd", 64'(rd_o), 64'd9);
    checkOutput("drain2_wdata", wdata_o, 64'd2);
    checkOutput("drain2_count", 64'(count_o), 64'd1);
    checkOutput("drain2_pend", 64'(pend_o), 64'h600);
    tick();
    checkOutput("drain3_rd", 64'(rd_o), 64'd10);
    checkOutput("drain3_wdata", wdata_o, 64'd3);
    checkOutput("drain3_count", 64'(count_o), 64'd0);
    checkOutput("drain3_pend", 64'(pend_o), 64'h400);
    tick();
    checkOutput("drain_done_wen", 64'(wen_o), 64'd0);
    checkOutput("drain_done_pend", 64'(pend_o), 64'd0);

    // md result to x0: accepted, never written.
    applyStimulus(0, 0, 0, 1, 0, 64'h55);
    #1;
    checkOutput("x0_ready", 64'(md_ready_o), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("x0_wen", 64'(wen_o), 64'd0);
    checkOutput("x0_pend", 64'(pend_o), 64'd0);
    checkOutput("x0_count", 64'(count_o), 64'd0);
    checkOutput("x0_hold_wdata", wdata_o, 64'd3);

    // Pipe write to x0 leaves the slot to the md bypass.
    applyStimulus(1, 0, 64'hDEAD, 1, 13, 64'h77);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("px0_wen", 64'(wen_o), 64'd1);
    checkOutput("px0_rd", 64'(rd_o), 64'd13);
    checkOutput("px0_wdata", wdata_o, 64'h77);
    checkOutput("px0_count", 64'(count_o), 64'd0);
    tick();

    // Async reset with two queued entries.
    applyStimulus(1, 1, 64'h1, 1, 11, 64'hB);
    tick();
    applyStimulus(1, 2, 64'h2, 1, 12, 64'hC);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pre_rst_count", 64'(count_o), 64'd2);
    checkOutput("pre_rst_pend", 64'(pend_o), 64'h1800);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_wen", 64'(wen_o), 64'd0);
    checkOutput("arst_count", 64'(count_o), 64'd0);
    checkOutput("arst_pend", 64'(pend_o), 64'd0);
    checkOutput("arst_ready", 64'(md_ready_o), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("post_rst_wen1", 64'(wen_o), 64'd0);
    tick();
    checkOutput("post_rst_wen2", 64'(wen_o), 64'd0);
    checkOutput("post_rst_count", 64'(count_o), 64'd0);
    checkOutput("post_rst_pend", 64'(pend_o), 64'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
